// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types for the decode->execute elastic buffer: controller sideband,
// execute-stage payload, and default sizing.
package pipe_stage_buffer_pkg;

  typedef enum logic [3:0] {
    OP1_REG  = 4'd0,
    OP1_PC   = 4'd1,
    OP1_ZERO = 4'd2,
    OP1_IMM  = 4'd3
  } AluOp1Type;

  typedef enum logic [2:0] {
    OP2_REG  = 3'd0,
    OP2_IMM  = 3'd1,
    OP2_FOUR = 3'd2,
    OP2_ZERO = 3'd3
  } AluOp2Type;

  typedef struct packed {
    AluOp1Type aluOp1Type;
    AluOp2Type aluOp2Type;
    logic      isStore;
  } PipeBufCtrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1Val;
    logic [31:0] op2Val;
  } ExecuteStagePipeReg;

  localparam int PIPE_BUF_CTRL_W        = $bits(PipeBufCtrl);
  localparam int PIPE_BUF_PAYLOAD_W     = $bits(ExecuteStagePipeReg);
  localparam int PIPE_BUF_DEPTH_DEFAULT = 2;

  // A single-entry buffer still needs a 1-bit pointer to index storage.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear; wraps by
// explicit compare so non-power-of-two depths work.
module pipe_buf_ptr
  import pipe_stage_buffer_pkg::*;
#(
  parameter int DEPTH = PIPE_BUF_DEPTH_DEFAULT,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// DEPTH-entry valid/ready elastic buffer between decode and execute, with flush,
// occupancy and head-sideband export. Optional same-cycle bypass: PIPE_STAGE_BUFFER_BYPASS_EN.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_BUF_PAYLOAD_W,
  parameter int CTRL_W    = PIPE_BUF_CTRL_W,
  parameter int DEPTH     = PIPE_BUF_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = PAYLOAD_W + CTRL_W;

  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic               stored_valid;
  logic               bypass_active;
  logic               push;
  logic               pop;
  logic               store_wr;
  logic               store_rd;

  assign in_entry     = {in_payload, in_ctrl};
  assign stored_valid = (occ_q != '0);
  assign in_ready     = (occ_q < OCC_W'(DEPTH));
  assign stall        = !in_ready;
  assign occupancy    = occ_q;

`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
  assign bypass_active = !stored_valid && in_valid && !flush;
  assign out_valid     = stored_valid || bypass_active;
  assign out_entry     = stored_valid ? mem[rd_ptr] : in_entry;
`else
  assign bypass_active = 1'b0;
  assign out_valid     = stored_valid;
  assign out_entry     = mem[rd_ptr];
`endif

  assign out_payload = out_valid ? out_entry[ENTRY_W-1:CTRL_W] : '0;
  assign out_ctrl    = out_valid ? out_entry[CTRL_W-1:0]       : '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // A bypassed entry that is consumed immediately never touches storage.
  assign store_wr = push && !(bypass_active && out_ready);
  assign store_rd = pop && !bypass_active;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (store_wr && !store_rd) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (store_rd && !store_wr) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (store_rd),
    .ptr (rd_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (store_wr),
    .ptr (wr_ptr)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (store_wr && (wr_ptr == PTR_W'(gi))) begin
          mem[gi] <= in_entry;
        end
      end
    end
  endgenerate

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised elastic buffer between decode and execute. It replaces the single-entry stall-and-hold hand-off with a DEPTH-entry FIFO.
- Interface is valid/ready on both sides, with a flush input and occupancy reporting.
- Exposes the head entry's control sideband (ALU operand types, store flag) to the hazard controller.

Parameters:
- PAYLOAD_W, 96, width of the execute-stage pipe register payload.
- CTRL_W, 8, width of the controller sideband (packed ALU op1/op2 types plus isStore).
- DEPTH, 2, number of entries; legal range 1..16, non-power-of-two allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an entry.
- in_ready  out  1  buffer accepts this cycle.
- in_payload  in  PAYLOAD_W  entry payload.
- in_ctrl  in  CTRL_W  entry controller sideband.
- flush  in  1  discard all entries (branch mispredict / trap).
- out_valid  out  1  head entry valid for execute.
- out_ready  in  1  execute consumes head this cycle.
- out_payload  out  PAYLOAD_W  head payload.
- out_ctrl  out  CTRL_W  head sideband, to the hazard controller.
- stall  out  1  equals !in_ready; drives the decode stage stall.
- occupancy  out  $clog2(DEPTH+1)  entries currently held.

Behaviour:
- Reset (rst=0, async): occupancy=0, read/write pointers=0, out_valid=0, in_ready=1, stall=0. out_payload and out_ctrl read 0. Storage contents are don't-care.
- Push happens when in_valid && in_ready && !flush. Pop happens when out_valid && out_ready && !flush.
- in_ready = (occupancy < DEPTH), registered-state only. There is no combinational path from out_ready to in_ready. When full, a pop in the same cycle does not enable a push.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 (without the optional feature).
- out_valid = (occupancy != 0). out_payload/out_ctrl come from storage at the read pointer and are forced to 0 when out_valid=0.
- Stability: while out_valid && !out_ready, out_payload and out_ctrl hold their values.
- Push and pop in the same cycle: occupancy unchanged and both pointers advance. Legal at any occupancy from 1 to DEPTH-1.
- Pointer arithmetic: pointers wrap from DEPTH-1 to 0 with an explicit compare, never a power-of-two mask.
- Occupancy update: +1 on push-only, -1 on pop-only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- flush: next cycle occupancy=0, pointers=0, out_valid=0. Any push or pop in the flush cycle is ignored.
- Reset asserted mid-transfer discards all entries immediately, with no partial update.
- DEPTH=1 degenerates to a full-throughput-halving hold register. This is the legacy behaviour and is legal.

Optional Feature:
- Macro: PIPE_STAGE_BUFFER_BYPASS_EN.
- Defined: when occupancy=0 and in_valid, out_valid=1 and out_payload/out_ctrl=in_* combinationally in the same cycle. If out_ready is also high, the entry is consumed without being written, giving 0-cycle latency. flush still suppresses out_valid.
- Undefined: the bypass path is absent and minimum latency is 1 cycle. No combinational in→out path exists.

Decomposition:
- BasicTypes package gains:
  - PipeBufCtrl packed struct (aluOp1Type, aluOp2Type, isStore), whose width sets CTRL_W.
  - PIPE_BUF_DEPTH_DEFAULT constant.
  - ExecuteStagePipeReg remains the payload type.
- One natural sub-module: pipe_buf_ptr, a wrapping modulo-DEPTH pointer with an increment enable and synchronous clear. Instantiated twice, once for read and once for write.

Test Plan:
- Reset, then push 0xA1 with out_ready=0. Cycle+1: out_valid=1, out_payload=0xA1, occupancy=1. Hold 5 cycles: value stable.
- Push 0x01 and 0x02 with out_ready=0. Occupancy=2, in_ready=0, stall=1. Assert out_ready and in_valid together: pop 0x01, no push accepted. Next cycle: in_ready=1.
- DEPTH=3: stream 10 entries 0x10..0x19 with out_ready toggling 1,0,1,0. All arrive in order with no loss or duplication, and occupancy never exceeds 3 (pointer-wrap check).
- With occupancy=2, assert flush together with in_valid=1 (0x55). Next cycle: occupancy=0, out_valid=0, and 0x55 never appears.
- Assert rst low mid-stream at occupancy=2, asynchronously between edges. Outputs clear immediately. After release, the first push of 0x77 appears 1 cycle later.
- With PIPE_STAGE_BUFFER_BYPASS_EN and empty: in_valid=1 (0x33) and out_ready=1. Same cycle: out_valid=1, out_payload=0x33, occupancy stays 0.
